// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: front end for the 32-bit combinational ALU.
// Buffers tagged commands in a small FIFO. Drives registered operands into the ALU.
// Captures the ALU result and returns it as a tagged valid/ready response.
module alu_cmd_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TAG_W      = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_cmd_valid,
   output logic              out_cmd_ready,
   input  logic [3:0]        in_cmd_op,
   input  logic [31:0]       in_cmd_a,
   input  logic [31:0]       in_cmd_b,
   input  logic [TAG_W-1:0]  in_cmd_tag,
   output logic [3:0]        out_alu_operation,
   output logic [31:0]       out_alu_A,
   output logic [31:0]       out_alu_B,
   input  logic [31:0]       in_alu_result,
   input  logic              in_alu_zero,
   output logic              out_rsp_valid,
   input  logic              in_rsp_ready,
   output logic [31:0]       out_rsp_result,
   output logic              out_rsp_zero,
   output logic              out_rsp_illegal,
   output logic [TAG_W-1:0]  out_rsp_tag,
   output logic              out_busy,
   output logic [CNT_W-1:0]  out_done_count
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   // command FIFO storage and pointers
   logic [3:0]       r_mem_op  [FIFO_DEPTH];
   logic [31:0]      r_mem_a   [FIFO_DEPTH];
   logic [31:0]      r_mem_b   [FIFO_DEPTH];
   logic [TAG_W-1:0] r_mem_tag [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   // FSM and operand/response registers
   state_t           r_state;
   logic [3:0]       r_alu_op;
   logic [31:0]      r_alu_a;
   logic [31:0]      r_alu_b;
   logic [TAG_W-1:0] r_op_tag;
   logic             r_op_illegal;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_result;
   logic             r_rsp_zero;
   logic             r_rsp_illegal;
   logic [TAG_W-1:0] r_rsp_tag;
   logic [CNT_W-1:0] r_done_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_hs;
   logic             w_pop;
   logic [3:0]       w_head_op;
   logic [31:0]      w_head_a;
   logic [31:0]      w_head_b;
   logic [TAG_W-1:0] w_head_tag;
   logic             w_head_illegal;

   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_push  = in_cmd_valid && !w_full;
   assign w_hs    = r_rsp_valid && in_rsp_ready;
   // IDLE pops only stored entries; a handshake may also take a command arriving this cycle
   assign w_pop   = ((r_state == S_IDLE) && !w_empty) ||
                    (w_hs && (!w_empty || w_push));

   // head of queue; when empty, a same-cycle push is forwarded straight to the operands
   always_comb begin
      w_head_op  = r_mem_op[r_rd_ptr];
      w_head_a   = r_mem_a[r_rd_ptr];
      w_head_b   = r_mem_b[r_rd_ptr];
      w_head_tag = r_mem_tag[r_rd_ptr];
      if (w_empty) begin
         w_head_op  = in_cmd_op;
         w_head_a   = in_cmd_a;
         w_head_b   = in_cmd_b;
         w_head_tag = in_cmd_tag;
      end
   end

   // legal-opcode decode of the head entry
   always_comb begin
      case (w_head_op)
         4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0111, 4'b1000: w_head_illegal = 1'b0;
         default:                   w_head_illegal = 1'b1;
      endcase
   end

   // FIFO storage write (no reset needed on the data array)
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_op[r_wr_ptr]  <= in_cmd_op;
         r_mem_a[r_wr_ptr]   <= in_cmd_a;
         r_mem_b[r_wr_ptr]   <= in_cmd_b;
         r_mem_tag[r_wr_ptr] <= in_cmd_tag;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // sequencing FSM: issue to ALU, capture result, hold response until accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_alu_op      <= '0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_op_tag      <= '0;
         r_op_illegal  <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_zero    <= 1'b0;
         r_rsp_illegal <= 1'b0;
         r_rsp_tag     <= '0;
         r_done_count  <= '0;
      end else begin
         if (w_pop) begin
            r_alu_op     <= w_head_op;
            r_alu_a      <= w_head_a;
            r_alu_b      <= w_head_b;
            r_op_tag     <= w_head_tag;
            r_op_illegal <= w_head_illegal;
         end
         case (r_state)
            S_IDLE: begin
               if (w_pop) r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_rsp_result  <= in_alu_result;
               r_rsp_zero    <= in_alu_zero;
               r_rsp_illegal <= r_op_illegal;
               r_rsp_tag     <= r_op_tag;
               r_rsp_valid   <= 1'b1;
               r_state       <= S_RESP;
            end
            S_RESP: begin
               if (w_hs) begin
                  r_rsp_valid  <= 1'b0;
                  r_done_count <= r_done_count + 1'b1;
                  r_state      <= w_pop ? S_EXEC : S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_cmd_ready     = !w_full;
   assign out_alu_operation = r_alu_op;
   assign out_alu_A         = r_alu_a;
   assign out_alu_B         = r_alu_b;
   assign out_rsp_valid     = r_rsp_valid;
   assign out_rsp_result    = r_rsp_result;
   assign out_rsp_zero      = r_rsp_zero;
   assign out_rsp_illegal   = r_rsp_illegal;
   assign out_rsp_tag       = r_rsp_tag;
   assign out_busy          = (r_state != S_IDLE) || !w_empty;
   assign out_done_count    = r_done_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached.
// The done counter is built 4 bits wide so that its wrap can be reached quickly.
module tb_alu_cmd_sequencer;

   localparam int unsigned TAG_W = 4;
   localparam int unsigned CNT_W = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_cmd_valid;
   logic              out_cmd_ready;
   logic [3:0]        in_cmd_op;
   logic [31:0]       in_cmd_a;
   logic [31:0]       in_cmd_b;
   logic [TAG_W-1:0]  in_cmd_tag;
   logic [3:0]        out_alu_operation;
   logic [31:0]       out_alu_A;
   logic [31:0]       out_alu_B;
   logic [31:0]       in_alu_result;
   logic              in_alu_zero;
   logic              out_rsp_valid;
   logic              in_rsp_ready;
   logic [31:0]       out_rsp_result;
   logic              out_rsp_zero;
   logic              out_rsp_illegal;
   logic [TAG_W-1:0]  out_rsp_tag;
   logic              out_busy;
   logic [CNT_W-1:0]  out_done_count;

   alu_cmd_sequencer #(.FIFO_DEPTH(4), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
      .in_cmd_op(in_cmd_op), .in_cmd_a(in_cmd_a), .in_cmd_b(in_cmd_b), .in_cmd_tag(in_cmd_tag),
      .out_alu_operation(out_alu_operation), .out_alu_A(out_alu_A), .out_alu_B(out_alu_B),
      .in_alu_result(in_alu_result), .in_alu_zero(in_alu_zero),
      .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
      .out_rsp_result(out_rsp_result), .out_rsp_zero(out_rsp_zero),
      .out_rsp_illegal(out_rsp_illegal), .out_rsp_tag(out_rsp_tag),
      .out_busy(out_busy), .out_done_count(out_done_count)
   );

   always #5 clk = ~clk;

   // behavioural ALU: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0111 SLT, 1000 LUI, others 0
   always_comb begin
      case (out_alu_operation)
         4'b0001: in_alu_result = out_alu_A + out_alu_B;
         4'b0010: in_alu_result = out_alu_A - out_alu_B;
         4'b0011: in_alu_result = out_alu_A & out_alu_B;
         4'b0100: in_alu_result = out_alu_A | out_alu_B;
         4'b0111: in_alu_result = {31'b0, $signed(out_alu_A) < $signed(out_alu_B)};
         4'b1000: in_alu_result = {out_alu_B[15:0], 16'h0000};
         default: in_alu_result = 32'h0;
      endcase
      in_alu_zero = (in_alu_result == 32'h0);
   end

   typedef struct packed {
      logic [31:0]      res;
      logic             zero;
      logic             ill;
      logic [TAG_W-1:0] tag;
   } rsp_t;

   rsp_t q_rsp[$];
   int   q_cyc[$];
   int   cyc = 0;
   int   n_err = 0;
   int   n_chk = 0;

   // record every response handshake with its cycle number
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && out_rsp_valid && in_rsp_ready) begin
         q_rsp.push_back('{out_rsp_result, out_rsp_zero, out_rsp_illegal, out_rsp_tag});
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tg);
      int unsigned n = 0;
      in_cmd_valid = 1'b1;
      in_cmd_op    = op;
      in_cmd_a     = a;
      in_cmd_b     = b;
      in_cmd_tag   = tg;
      while (!out_cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_cmd_ready) check("push_timeout", 64'(out_cmd_ready), 64'd1);
      else @(posedge clk);
      @(negedge clk);
      in_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while ((out_busy || out_rsp_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(out_busy), 64'd0);
   endtask

   task automatic check_rsp(input string tag, input int idx, input logic [31:0] res,
                            input logic zero, input logic ill, input logic [TAG_W-1:0] tg);
      if (idx >= q_rsp.size()) begin
         check({tag, "_missing"}, 64'(q_rsp.size()), 64'(idx + 1));
      end else begin
         check({tag, "_res"},  64'(q_rsp[idx].res),  64'(res));
         check({tag, "_zero"}, 64'(q_rsp[idx].zero), 64'(zero));
         check({tag, "_ill"},  64'(q_rsp[idx].ill),  64'(ill));
         check({tag, "_tag"},  64'(q_rsp[idx].tag),  64'(tg));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [31:0] t3_a   [6] = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600};
   logic        t3_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [31:0] t3_res [5] = '{32'd101, 32'd202, 32'd303, 32'd404, 32'd505};
   logic [31:0] t6_res [6] = '{32'd1001, 32'd1002, 32'd1003, 32'd1004, 32'd1005, 32'd1006};

   initial begin
      reset        = 1'b1;
      in_cmd_valid = 1'b0;
      in_cmd_op    = '0;
      in_cmd_a     = '0;
      in_cmd_b     = '0;
      in_cmd_tag   = '0;
      in_rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      check("rst_ready", 64'(out_cmd_ready), 64'd1);
      check("rst_valid", 64'(out_rsp_valid), 64'd0);
      check("rst_busy",  64'(out_busy), 64'd0);
      check("rst_done",  64'(out_done_count), 64'd0);
      check("rst_op",    64'(out_alu_operation), 64'd0);
      check("rst_A",     64'(out_alu_A), 64'd0);
      check("rst_res",   64'(out_rsp_result), 64'd0);

      // single ADD: latency and handshake
      push(4'b0001, 32'd5, 32'd7, 4'd3);
      check("t1_valid_n1", 64'(out_rsp_valid), 64'd0);
      @(negedge clk);
      check("t1_valid_n2", 64'(out_rsp_valid), 64'd0);
      check("t1_alu_op", 64'(out_alu_operation), 64'd1);
      check("t1_alu_A",  64'(out_alu_A), 64'd5);
      check("t1_alu_B",  64'(out_alu_B), 64'd7);
      @(negedge clk);
      check("t1_valid", 64'(out_rsp_valid), 64'd1);
      check("t1_res",   64'(out_rsp_result), 64'd12);
      check("t1_zero",  64'(out_rsp_zero), 64'd0);
      check("t1_tag",   64'(out_rsp_tag), 64'd3);
      check("t1_ill",   64'(out_rsp_illegal), 64'd0);
      in_rsp_ready = 1'b1;
      @(negedge clk);
      in_rsp_ready = 1'b0;
      check("t1_valid_after", 64'(out_rsp_valid), 64'd0);
      check("t1_done", 64'(out_done_count), 64'd1);

      // back-to-back ordering with ready held high
      q_rsp.delete();
      q_cyc.delete();
      in_rsp_ready = 1'b1;
      push(4'b0010, 32'd9, 32'd9, 4'd1);
      push(4'b0111, 32'd2, 32'd3, 4'd2);
      push(4'b1000, 32'd0, 32'h0000_0001, 4'd4);
      wait_idle("t2_idle");
      check("t2_count", 64'(q_rsp.size()), 64'd3);
      check_rsp("t2_r0", 0, 32'd0, 1'b1, 1'b0, 4'd1);
      check_rsp("t2_r1", 1, 32'd1, 1'b0, 1'b0, 4'd2);
      check_rsp("t2_r2", 2, 32'h0001_0000, 1'b0, 1'b0, 4'd4);
      if (q_cyc.size() == 3) begin
         check("t2_gap01", 64'(q_cyc[1] - q_cyc[0]), 64'd2);
         check("t2_gap12", 64'(q_cyc[2] - q_cyc[1]), 64'd2);
      end
      check("t2_done", 64'(out_done_count), 64'd4);

      // backpressure and full FIFO
      in_rsp_ready = 1'b0;
      q_rsp.delete();
      for (int i = 0; i < 6; i++) begin
         in_cmd_valid = 1'b1;
         in_cmd_op    = 4'b0001;
         in_cmd_a     = t3_a[i];
         in_cmd_b     = 32'(i + 1);
         in_cmd_tag   = TAG_W'(i + 9);
         check($sformatf("t3_ready%0d", i), 64'(out_cmd_ready), 64'(t3_rdy[i]));
         @(negedge clk);
      end
      in_cmd_valid = 1'b0;
      check("t3_busy", 64'(out_busy), 64'd1);
      for (int k = 0; k < 10; k++) begin
         check("t3_hold_valid", 64'(out_rsp_valid), 64'd1);
         check("t3_hold_res",   64'(out_rsp_result), 64'd101);
         check("t3_hold_tag",   64'(out_rsp_tag), 64'd9);
         @(negedge clk);
      end
      in_rsp_ready = 1'b1;
      wait_idle("t3_idle");
      check("t3_count", 64'(q_rsp.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         check_rsp($sformatf("t3_r%0d", i), i, t3_res[i], 1'b0, 1'b0, TAG_W'(i + 9));
      check("t3_done", 64'(out_done_count), 64'd9);

      // illegal opcode
      q_rsp.delete();
      push(4'b0101, 32'd1, 32'd1, 4'd7);
      wait_idle("t4_idle");
      check("t4_count", 64'(q_rsp.size()), 64'd1);
      check_rsp("t4_r0", 0, 32'd0, 1'b1, 1'b1, 4'd7);
      check("t4_done", 64'(out_done_count), 64'd10);

      // reset while in RESP with two commands queued
      in_rsp_ready = 1'b0;
      push(4'b0001, 32'd1, 32'd1, 4'd1);
      push(4'b0001, 32'd2, 32'd2, 4'd2);
      push(4'b0001, 32'd3, 32'd3, 4'd3);
      check("t5_in_resp", 64'(out_rsp_valid), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_valid", 64'(out_rsp_valid), 64'd0);
      check("t5_busy",  64'(out_busy), 64'd0);
      check("t5_ready", 64'(out_cmd_ready), 64'd1);
      check("t5_done",  64'(out_done_count), 64'd0);
      check("t5_op",    64'(out_alu_operation), 64'd0);
      q_rsp.delete();
      in_rsp_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("t5_no_stale", 64'(q_rsp.size()), 64'd0);
      check("t5_valid_late", 64'(out_rsp_valid), 64'd0);

      // simultaneous push and pop with three entries queued
      in_rsp_ready = 1'b0;
      push(4'b0001, 32'd1, 32'd1000, 4'd1);
      push(4'b0001, 32'd2, 32'd1000, 4'd2);
      push(4'b0001, 32'd3, 32'd1000, 4'd3);
      push(4'b0001, 32'd4, 32'd1000, 4'd4);
      check("t6_in_resp", 64'(out_rsp_valid), 64'd1);
      check("t6_ready_3", 64'(out_cmd_ready), 64'd1);
      in_rsp_ready = 1'b1;
      push(4'b0001, 32'd5, 32'd1000, 4'd5);
      in_rsp_ready = 1'b0;
      check("t6_ready_after", 64'(out_cmd_ready), 64'd1);
      push(4'b0001, 32'd6, 32'd1000, 4'd6);
      check("t6_full", 64'(out_cmd_ready), 64'd0);
      in_rsp_ready = 1'b1;
      wait_idle("t6_idle");
      check("t6_count", 64'(q_rsp.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         check_rsp($sformatf("t6_r%0d", i), i, t6_res[i], 1'b0, 1'b0, TAG_W'(i + 1));
      check("t6_done", 64'(out_done_count), 64'd6);

      // done counter wraps: 6 + 10 completions on a 4-bit counter
      for (int i = 0; i < 10; i++)
         push(4'b0011, 32'hFFFF_0000, 32'h0000_FFFF, 4'd0);
      wait_idle("t7_idle");
      check("t7_wrap", 64'(out_done_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
